// File: rtl/ddr4_pkg.sv
// Shared DDR4 command-decode definitions: one-hot command bit positions,
// power-state encoding and bank-count derivation.
package ddr4_pkg;

    localparam int unsigned CMD_WIDTH = 19;

    localparam int unsigned CMD_ACT  = 18;
    localparam int unsigned CMD_BST  = 17;
    localparam int unsigned CMD_CFG  = 16;
    localparam int unsigned CMD_CKEH = 15;
    localparam int unsigned CMD_CKEL = 14;
    localparam int unsigned CMD_DPD  = 13;
    localparam int unsigned CMD_DPDX = 12;
    localparam int unsigned CMD_MRR  = 11;
    localparam int unsigned CMD_MRW  = 10;
    localparam int unsigned CMD_PD   = 9;
    localparam int unsigned CMD_PDX  = 8;
    localparam int unsigned CMD_PR   = 7;
    localparam int unsigned CMD_PRA  = 6;
    localparam int unsigned CMD_RD   = 5;
    localparam int unsigned CMD_RDA  = 4;
    localparam int unsigned CMD_REF  = 3;
    localparam int unsigned CMD_SRF  = 2;
    localparam int unsigned CMD_WR   = 1;
    localparam int unsigned CMD_WRA  = 0;

    // Address bit that selects auto-precharge (RD/WR) or all-banks (PRE)
    localparam int unsigned A10_BIT = 10;

    typedef enum logic [1:0] {
        PWR_ACTIVE  = 2'd0,
        PWR_PWRDN   = 2'd1,
        PWR_SELFREF = 2'd2
    } pwr_state_t;

    function automatic int unsigned bank_groups(input int unsigned bgwidth);
        return 32'd1 << bgwidth;
    endfunction

    function automatic int unsigned banks_per_group(input int unsigned bawidth);
        return 32'd1 << bawidth;
    endfunction

endpackage

// File: rtl/ddr4_open_row_table.sv
// Per-bank open-row table: {valid,row} per bank with set, clear,
// clear-all and a combinational read port.
module ddr4_open_row_table
    import ddr4_pkg::*;
#(
    parameter int unsigned NBANKS = 16,
    parameter int unsigned IDXW   = 4,
    parameter int unsigned ROWW   = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [IDXW-1:0] set_idx,
    input  logic [ROWW-1:0] set_row,
    input  logic            clr_en,
    input  logic [IDXW-1:0] clr_idx,
    input  logic            clr_all,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_valid,
    output logic [ROWW-1:0] rd_row,
    output logic            any_open
);

    logic [NBANKS-1:0] valid_q, valid_d;
    logic [ROWW-1:0]   row_q [NBANKS];
    logic [ROWW-1:0]   row_d [NBANKS];

    // Next table contents from the set/clear requests
    always_comb begin
        valid_d = valid_q;
        row_d   = row_q;
        if (clr_all) begin
            valid_d = '0;
        end else if (clr_en) begin
            valid_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            valid_d[set_idx] = 1'b1;
            row_d[set_idx]   = set_row;
        end
    end

    // Table storage; reset closes every bank
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < NBANKS; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            row_q   <= row_d;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_row   = row_q[rd_idx];
    assign any_open = |valid_q;

endmodule

// File: rtl/ddr4_cmd_decode.sv
// DDR4 pin-level command decoder: decodes CA pins into the one-hot command
// vector, tracks CKE power state and open rows, flags protocol errors.
module ddr4_cmd_decode
    import ddr4_pkg::*;
#(
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned COLWIDTH  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cke,
    input  logic                 cs_n,
    input  logic                 act_n,
    input  logic                 ras_n,
    input  logic                 cas_n,
    input  logic                 we_n,
    input  logic [BGWIDTH-1:0]   bg,
    input  logic [BAWIDTH-1:0]   ba,
    input  logic [ADDRWIDTH-1:0] addr,
    output logic [18:0]          commands,
    output logic [BGWIDTH-1:0]   bg_q,
    output logic [BAWIDTH-1:0]   ba_q,
    output logic [ADDRWIDTH-1:0] row_q,
    output logic [COLWIDTH-1:0]  col_q,
    output logic [1:0]           pwr_state,
    output logic                 proto_err
);

    localparam int unsigned BANKGROUPS    = bank_groups(BGWIDTH);
    localparam int unsigned BANKSPERGROUP = banks_per_group(BAWIDTH);
    localparam int unsigned NBANKS        = BANKGROUPS * BANKSPERGROUP;
    localparam int unsigned IDXW          = BGWIDTH + BAWIDTH;

    pwr_state_t             pwr_state_q, pwr_state_d;
    logic                   cke_prev_q, cke_prev_d;
    logic [CMD_WIDTH-1:0]   commands_q, commands_d;
    logic                   proto_err_q, proto_err_d;
    logic [BGWIDTH-1:0]     bg_d;
    logic [BAWIDTH-1:0]     ba_d;
    logic [ADDRWIDTH-1:0]   row_d;
    logic [COLWIDTH-1:0]    col_d;

    logic [2:0]             rcw;
    logic                   a10;
    logic [IDXW-1:0]        bank_idx;
    logic                   cke_run, cke_fall, cke_rise;
    logic                   sel_ref, sel_nop;

    logic                   tbl_set, tbl_clr, tbl_clr_all;
    logic                   tbl_valid, tbl_any_open;
    logic [ADDRWIDTH-1:0]   tbl_row;

    assign rcw      = {ras_n, cas_n, we_n};
    assign a10      = addr[A10_BIT];
    assign bank_idx = {bg, ba};
    assign cke_run  = cke_prev_q & cke;
    assign cke_fall = cke_prev_q & ~cke;
    assign cke_rise = ~cke_prev_q & cke;
    assign sel_ref  = ~cs_n & act_n & (rcw == 3'b001);
    assign sel_nop  = cs_n | (act_n & (rcw == 3'b111));

    ddr4_open_row_table #(
        .NBANKS (NBANKS),
        .IDXW   (IDXW),
        .ROWW   (ADDRWIDTH)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .set_en   (tbl_set),
        .set_idx  (bank_idx),
        .set_row  (addr),
        .clr_en   (tbl_clr),
        .clr_idx  (bank_idx),
        .clr_all  (tbl_clr_all),
        .rd_idx   (bank_idx),
        .rd_valid (tbl_valid),
        .rd_row   (tbl_row),
        .any_open (tbl_any_open)
    );

    // Power-state and pin registers; reset forces ACTIVE and cke_prev high
    always_ff @(posedge clk) begin
        if (rst) begin
            pwr_state_q <= PWR_ACTIVE;
            cke_prev_q  <= 1'b1;
            commands_q  <= '0;
            proto_err_q <= 1'b0;
            bg_q        <= '0;
            ba_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            pwr_state_q <= pwr_state_d;
            cke_prev_q  <= cke_prev_d;
            commands_q  <= commands_d;
            proto_err_q <= proto_err_d;
            bg_q        <= bg_d;
            ba_q        <= ba_d;
            row_q       <= row_d;
            col_q       <= col_d;
        end
    end

    // Power-state transitions on CKE edges
    always_comb begin
        pwr_state_d = pwr_state_q;
        cke_prev_d  = cke;
        if (cke_fall) begin
            pwr_state_d = sel_ref ? PWR_SELFREF : PWR_PWRDN;
        end else if (cke_rise) begin
            pwr_state_d = PWR_ACTIVE;
        end
    end

    // Command decode, error detection and open-row table requests
    always_comb begin
        commands_d  = '0;
        proto_err_d = 1'b0;
        row_d       = '0;
        bg_d        = bg;
        ba_d        = ba;
        col_d       = addr[COLWIDTH-1:0];
        tbl_set     = 1'b0;
        tbl_clr     = 1'b0;
        tbl_clr_all = 1'b0;

        if (cke_run) begin
            if (!cs_n) begin
                if (!act_n) begin
                    commands_d[CMD_ACT] = 1'b1;
                    row_d               = addr;
                    proto_err_d         = tbl_valid;
                    tbl_set             = ~tbl_valid;
                end else begin
                    case (rcw)
                        3'b000: begin
                            commands_d[CMD_MRW] = 1'b1;
                            proto_err_d         = tbl_any_open;
                        end
                        3'b001: begin
                            commands_d[CMD_REF] = 1'b1;
                            proto_err_d         = tbl_any_open;
                        end
                        3'b010: begin
                            if (a10) begin
                                commands_d[CMD_PRA] = 1'b1;
                                tbl_clr_all         = 1'b1;
                            end else begin
                                commands_d[CMD_PR] = 1'b1;
                                tbl_clr            = 1'b1;
                            end
                        end
                        3'b101, 3'b100: begin
                            if (rcw[0]) begin
                                commands_d[a10 ? CMD_RDA : CMD_RD] = 1'b1;
                            end else begin
                                commands_d[a10 ? CMD_WRA : CMD_WR] = 1'b1;
                            end
                            row_d       = tbl_valid ? tbl_row : '0;
                            proto_err_d = ~tbl_valid;
                            tbl_clr     = a10 & tbl_valid;
                        end
                        3'b110: commands_d[CMD_CFG] = 1'b1;
                        3'b011: proto_err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
        end else if (cke_fall) begin
            // Only REF or NOP/DES are legal alongside CKE falling
            commands_d[CMD_CKEL] = 1'b1;
            if (sel_ref) begin
                commands_d[CMD_SRF] = 1'b1;
                proto_err_d         = tbl_any_open;
            end else if (sel_nop) begin
                commands_d[CMD_PD] = 1'b1;
            end else begin
                proto_err_d = 1'b1;
            end
        end else if (cke_rise) begin
            commands_d[CMD_CKEH] = 1'b1;
            commands_d[CMD_PDX]  = (pwr_state_q == PWR_PWRDN);
        end
    end

    assign commands  = commands_q;
    assign proto_err = proto_err_q;
    assign pwr_state = pwr_state_q;

endmodule
